// File: rtl/lsu_if.sv
// lsu_if: request/response handshake and word-memory bus of the load/store unit.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_read;
    logic        mem_write;
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_write_data, mem_read, mem_write
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word loads and stores to a word memory, sub-word stores by read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being silently aligned.
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input logic clk,
    input logic rst_n,
    lsu_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_READ, RMW_WRITE, RESP} state_t;
    localparam logic [31:0] MW = MEM_WORDS;
    state_t      state;
    logic [2:0]  f3_r;
    logic [1:0]  off_r;
    logic [31:0] wdata_r;
    logic        legal, mis, err;
    logic [4:0]  sh_b, sh_m;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ld, mask, mg;
    always_comb begin
        legal = bus.req_we ? (bus.req_funct3 <= 3'd2) : (bus.req_funct3 != 3'd3 && bus.req_funct3 <= 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) || (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'd0);
`else
        mis = 1'b0;
`endif
        err = !legal || mis || ({2'b00, bus.req_addr[31:2]} >= MW);
        sh_b = {off_r, 3'b000};
        byte_v = 8'(bus.mem_read_data >> sh_b);
        half_v = off_r[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
        ld = f3_r[1] ? bus.mem_read_data :
             f3_r[0] ? {{16{half_v[15] & ~f3_r[2]}}, half_v} : {{24{byte_v[7] & ~f3_r[2]}}, byte_v};
        // halfword offset uses addr[1] only, so an odd halfword address aligns down
        sh_m = f3_r[0] ? {off_r[1], 4'b0000} : sh_b;
        mask = (f3_r[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh_m;
        mg = (bus.mem_read_data & ~mask) | ((wdata_r << sh_m) & mask);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bus.req_ready <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err <= 1'b0;
            bus.resp_rdata <= '0;
            bus.mem_read <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_write_data <= '0;
            f3_r <= '0;
            off_r <= '0;
            wdata_r <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    bus.req_ready <= 1'b0;
                    f3_r <= bus.req_funct3;
                    off_r <= bus.req_addr[1:0];
                    wdata_r <= bus.req_wdata;
                    bus.mem_addr <= {bus.req_addr[31:2], 2'b00};
                    if (err) begin
                        state <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err <= 1'b1;
                        bus.resp_rdata <= '0;
                    end else if (!bus.req_we) begin
                        state <= LOAD;
                        bus.mem_read <= 1'b1;
                    end else if (bus.req_funct3[1]) begin
                        state <= WRITE;
                        bus.mem_write <= 1'b1;
                        bus.mem_write_data <= bus.req_wdata;
                    end else begin
                        state <= RMW_READ;
                        bus.mem_read <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= RESP;
                    bus.mem_read <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err <= 1'b0;
                    bus.resp_rdata <= ld;
                end
                RMW_READ: begin
                    state <= RMW_WRITE;
                    bus.mem_read <= 1'b0;
                    bus.mem_write <= 1'b1;
                    bus.mem_write_data <= mg;
                end
                WRITE, RMW_WRITE: begin
                    state <= RESP;
                    bus.mem_write <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err <= 1'b0;
                    bus.resp_rdata <= '0;
                end
                RESP: begin
                    state <= IDLE;
                    bus.req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench against a byte-addressed reference memory model.
module tb_load_store_unit;
    logic clk = 0;
    logic rst_n = 0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    lsu_if bus ();
    load_store_unit #(.MEM_WORDS(256)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] dmem [256];
    logic [7:0]  rmem [1024];
    assign bus.mem_read_data = dmem[bus.mem_addr[9:2]];
    always @(posedge clk) if (bus.mem_write) dmem[bus.mem_addr[9:2]] <= bus.mem_write_data;

    typedef struct { logic err; logic [31:0] rdata; int cyc; } resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    resp_t sq[$];
    wr_t   wq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rword(input int w);
        return {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]};
    endfunction

    // reference semantics: size from funct3, address aligned down to the access size
    task automatic ref_access(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                              output bit er, output logic [31:0] rd, output int lat);
        int sz, ea;
        logic [31:0] v;
        bit legal;
        legal = we ? (f3 <= 2) : (f3 != 3 && f3 <= 5);
        sz = 1 << f3[1:0];
        er = !legal || (a >= 32'h400);
`ifdef LSU_MISALIGN_TRAP_EN
        if (legal && sz > 1 && (a % sz) != 0) er = 1;
`endif
        rd = 0;
        lat = 1;
        if (er) return;
        ea = int'(a) & ~(sz - 1);
        if (!we) begin
            v = 0;
            for (int i = 0; i < sz; i++) v |= 32'(rmem[ea+i]) << (8*i);
            if (!f3[2] && sz < 4 && v[8*sz-1]) v |= 32'hFFFF_FFFF << (8*sz);
            rd = v;
            lat = 2;
        end else begin
            for (int i = 0; i < sz; i++) rmem[ea+i] = 8'(wd >> (8*i));
            lat = (sz == 4) ? 2 : 3;
        end
    endtask

    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n, lat;
        bit er;
        logic [31:0] rd;
        resp_t e;
        wr_t w;
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
        n = 0;
        while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
        if (!bus.req_ready) begin
            chk("accept_timeout", 0, 1);
            bus.req_valid = 0;
            return;
        end
        ref_access(we, f3, a, wd, er, rd, lat);
        e.err = er; e.rdata = rd; e.cyc = cyc + lat;
        sq.push_back(e);
        if (we && !er) begin
            w.addr = {a[31:2], 2'b00}; w.data = rword(int'(a[9:2]));
            wq.push_back(w);
        end
        @(posedge clk);
        #1 bus.req_valid = 0;
        if (er) begin
            @(negedge clk);
            chk("err_no_strobe", {30'b0, bus.mem_read, bus.mem_write}, 0);
        end
    endtask

    always @(negedge clk) begin
        resp_t e;
        wr_t w;
        if (bus.mem_read && bus.mem_write) chk("strobe_overlap", 1, 0);
        if (bus.mem_write) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                w = wq.pop_front();
                chk("write_addr", bus.mem_addr, w.addr);
                chk("write_data", bus.mem_write_data, w.data);
            end
        end
        if (rst_n && bus.resp_valid) begin
            if (sq.size() == 0) chk("unexpected_resp", 1, 0);
            else begin
                e = sq.pop_front();
                chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
                chk("resp_rdata", bus.resp_rdata, e.rdata);
                chk("resp_latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, wd, w0;
        int n;
        bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0; bus.req_addr = 0; bus.req_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            w0 = (i == 4) ? 32'h8899_AABB : $urandom;
            dmem[i] = w0;
            for (int b = 0; b < 4; b++) rmem[4*i+b] = 8'(w0 >> (8*b));
        end
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'b0, bus.req_ready}, 1);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 0);
        chk("rst_resp_err", {31'b0, bus.resp_err}, 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_strobes", {30'b0, bus.mem_read, bus.mem_write}, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_write_data, 0);
        rst_n = 1;
        issue(0, 3'b000, 32'h11, 0);
        issue(0, 3'b100, 32'h13, 0);
        issue(0, 3'b101, 32'h12, 0);
        issue(1, 3'b001, 32'h12, 32'hDEAD_1234);
        issue(0, 3'b010, 32'h10, 0);
        issue(1, 3'b010, 32'h20, 32'hCAFE_F00D);
        issue(0, 3'b010, 32'h20, 0);
        issue(0, 3'b010, 32'h400, 0);
        issue(0, 3'b011, 32'h0, 0);
        issue(1, 3'b100, 32'h8, 0);
        issue(0, 3'b010, 32'h12, 0);
        issue(0, 3'b001, 32'h13, 0);
        for (int k = 0; k < 300; k++) begin
            a = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, 1023));
            wd = $urandom;
            issue(1'($urandom), ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5)), a, wd);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        n = 0;
        while (sq.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("drain_resp", sq.size(), 0);
        // store byte, then reset while its merged write is on the bus
        @(negedge clk);
        a = 32'h0000_0045; wd = $urandom;
        w0 = rword(17);
        w0[15:8] = wd[7:0];
        bus.req_valid = 1; bus.req_we = 1; bus.req_funct3 = 3'b000; bus.req_addr = a; bus.req_wdata = wd;
        wq.push_back('{addr: 32'h44, data: w0});
        @(posedge clk);
        #1 bus.req_valid = 0;
        n = 0;
        while (!bus.mem_write && n < 10) begin @(negedge clk); n++; end
        chk("rmw_write_seen", {31'b0, bus.mem_write}, 1);
        #2 rst_n = 0;
        #1;
        chk("abort_mem_write", {31'b0, bus.mem_write}, 0);
        chk("abort_resp_valid", {31'b0, bus.resp_valid}, 0);
        chk("abort_req_ready", {31'b0, bus.req_ready}, 1);
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("post_abort_ready", {31'b0, bus.req_ready}, 1);
        issue(0, 3'b010, 32'h44, 0);
        n = 0;
        while (sq.size() != 0 && n < 50) begin @(negedge clk); n++; end
        chk("drain_final", sq.size(), 0);
        chk("drain_writes", wq.size(), 0);
        for (int i = 0; i < 256; i++) chk("mem_image", dmem[i], rword(i));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
